// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants, counter width and controller state encoding.
package vga_timing_pkg;
  localparam int CNT_W = 10;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int   DEF_CLK_PER_PIXEL = 2;
  localparam logic DEF_SYNC_ACTIVE   = 1'b0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } vgaState_t;
endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: wrapping position counter plus registered sync/visible flags
// derived from the next count, so the flags line up with count on the same Clk.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = DEF_H_TOTAL,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 751,
  parameter int VISIBLE    = DEF_H_VISIBLE
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             syncActive,
  output logic             visible
);
  logic             atLast;
  logic [CNT_W-1:0] countNext;

  assign atLast = (count == CNT_W'(TOTAL - 1));
  assign wrap   = advance && atLast;

  always_comb begin
    countNext = count;
    if (clear)
      countNext = '0;
    else if (advance)
      countNext = atLast ? '0 : count + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count      <= '0;
      syncActive <= 1'b0;
      visible    <= 1'b0;
    end else begin
      count      <= countNext;
      syncActive <= !clear && (countNext >= CNT_W'(SYNC_START)) && (countNext <= CNT_W'(SYNC_END));
      visible    <= !clear && (countNext < CNT_W'(VISIBLE));
    end
  end
endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: run/stop FSM that only halts on a frame boundary, pixel prescaler, H/V axes.
// IDLE: outputs at reset values | RUN: counting | STOPPING: counting, drop to IDLE at frame end
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE     = DEF_H_VISIBLE,
  parameter int   H_FRONT       = DEF_H_FRONT,
  parameter int   H_SYNC        = DEF_H_SYNC,
  parameter int   H_BACK        = DEF_H_BACK,
  parameter int   V_VISIBLE     = DEF_V_VISIBLE,
  parameter int   V_FRONT       = DEF_V_FRONT,
  parameter int   V_SYNC        = DEF_V_SYNC,
  parameter int   V_BACK        = DEF_V_BACK,
  parameter int   CLK_PER_PIXEL = DEF_CLK_PER_PIXEL,
  parameter logic SYNC_ACTIVE   = DEF_SYNC_ACTIVE
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  output logic             Running,
  output logic             PixelTick,
  output logic [CNT_W-1:0] HCount,
  output logic [CNT_W-1:0] VCount,
  output logic             HSync,
  output logic             VSync,
  output logic             VideoOn,
  output logic             FrameStart
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int PRE_W   = (CLK_PER_PIXEL > 1) ? $clog2(CLK_PER_PIXEL) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_PIXEL - 1);

  vgaState_t        state, nextState;
  logic [PRE_W-1:0] prescaler, prescalerNext;
  logic             goIdle, frameEnd, hWrap;
  logic             hSyncOn, vSyncOn, hVisible, vVisible;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (Enable) nextState = RUN;
      RUN:      if (!Enable) nextState = STOPPING;
      STOPPING: if (Enable) nextState = RUN;
                else if (frameEnd) nextState = IDLE;
      default:  nextState = IDLE;
    endcase

    goIdle = (nextState == IDLE);

    // Prescaler restarts at 0 on the first RUN Clk and whenever the controller parks.
    prescalerNext = '0;
    if (!goIdle && state != IDLE && prescaler != PRE_LAST)
      prescalerNext = prescaler + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      state <= IDLE;
    else
      state <= nextState;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prescaler  <= '0;
      Running    <= 1'b0;
      PixelTick  <= 1'b0;
      FrameStart <= 1'b0;
    end else begin
      prescaler  <= prescalerNext;
      Running    <= !goIdle;
      PixelTick  <= !goIdle && (prescalerNext == PRE_LAST);
      FrameStart <= !goIdle && ((state == IDLE) || frameEnd);
    end
  end

  vga_axis_counter #(
    .TOTAL     (H_TOTAL),
    .SYNC_START(H_VISIBLE + H_FRONT),
    .SYNC_END  (H_VISIBLE + H_FRONT + H_SYNC - 1),
    .VISIBLE   (H_VISIBLE)
  ) uHAxis (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (goIdle),
    .advance   (PixelTick),
    .count     (HCount),
    .wrap      (hWrap),
    .syncActive(hSyncOn),
    .visible   (hVisible)
  );

  // The vertical wrap is exactly the last pixel of the frame.
  vga_axis_counter #(
    .TOTAL     (V_TOTAL),
    .SYNC_START(V_VISIBLE + V_FRONT),
    .SYNC_END  (V_VISIBLE + V_FRONT + V_SYNC - 1),
    .VISIBLE   (V_VISIBLE)
  ) uVAxis (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (goIdle),
    .advance   (hWrap),
    .count     (VCount),
    .wrap      (frameEnd),
    .syncActive(vSyncOn),
    .visible   (vVisible)
  );

  assign HSync   = hSyncOn ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign VSync   = vSyncOn ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign VideoOn = hVisible & vVisible;
endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench on a shrunken raster (16x12 pixels, 2 Clk/pixel => 384 Clk per frame).
module tb_vga_timing_controller;
  import vga_timing_pkg::*;

  localparam int HT = 16;
  localparam int VT = 12;
  localparam int FRAME = HT * VT * 2;
  localparam logic [25:0] IDLE_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0};

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             Enable = 1'b0;
  logic             Running, PixelTick, HSync, VSync, VideoOn, FrameStart;
  logic [CNT_W-1:0] HCount, VCount;

  int nChk = 0;
  int nBad = 0;
  int hsLow, vsLow, voCnt, tickCnt, nFs;
  int fsT[2];

  vga_timing_controller #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .CLK_PER_PIXEL(2), .SYNC_ACTIVE(1'b0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable),
    .Running(Running), .PixelTick(PixelTick),
    .HCount(HCount), .VCount(VCount),
    .HSync(HSync), .VSync(VSync), .VideoOn(VideoOn), .FrameStart(FrameStart)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] dutVec();
    return {Running, PixelTick, FrameStart, HSync, VSync, VideoOn, HCount, VCount};
  endfunction

  // Expected outputs t Clk after the first RUN Clk of an uninterrupted run.
  function automatic logic [25:0] expRun(int t);
    int p, h, v;
    logic tick, fs, hs, vs, vo;
    p    = t / 2;
    h    = p % HT;
    v    = (p / HT) % VT;
    tick = (t % 2) == 1;
    fs   = (t % FRAME) == 0;
    hs   = !(h >= 10 && h <= 12);
    vs   = !(v >= 8 && v <= 9);
    vo   = (h < 8) && (v < 6);
    return {1'b1, tick, fs, hs, vs, vo, 10'(h), 10'(v)};
  endfunction

  // Called at the negedge of the first RUN Clk; leaves at the negedge of cycle len.
  task automatic runPhase(input string tag, input int len, input int idleFrom,
                          input int off1, input int on1, input int off2);
    logic [25:0] exp;
    hsLow = 0; vsLow = 0; voCnt = 0; tickCnt = 0; nFs = 0;
    for (int t = 0; t < len; t++) begin
      if (t == off1) Enable = 1'b0;
      if (t == on1)  Enable = 1'b1;
      if (t == off2) Enable = 1'b0;
      exp = (t >= idleFrom) ? IDLE_VEC : expRun(t);
      check($sformatf("%s t=%0d", tag, t), 32'(dutVec()), 32'(exp));
      if (t < FRAME) begin
        if (VCount == 0 && HSync == 1'b0) hsLow++;
        if (VSync == 1'b0) vsLow++;
        if (VideoOn) voCnt++;
        if (PixelTick) tickCnt++;
      end
      if (FrameStart && nFs < 2) begin
        fsT[nFs] = t;
        nFs++;
      end
      @(negedge Clk);
    end
  endtask

  initial begin
    Reset  = 1'b0;
    Enable = 1'b1;
    repeat (3) @(negedge Clk);
    check("rstVec", 32'(dutVec()), 32'(IDLE_VEC));

    // Frames 1-2 free-running; Enable dropped and re-raised inside frame 3 (no restart);
    // dropped again in frame 4, so IDLE follows the end of frame 4.
    Reset = 1'b1;
    @(negedge Clk);
    runPhase("runA", 4 * FRAME + 8, 4 * FRAME,
             2 * FRAME + 3 * HT * 2, 2 * FRAME + 7 * HT * 2, 3 * FRAME + 3 * HT * 2);
    check("hsLowLine0", 32'(hsLow), 32'd6);
    check("vsLowFrame", 32'(vsLow), 32'd64);
    check("videoOnFrame", 32'(voCnt), 32'd96);
    check("ticksFrame", 32'(tickCnt), 32'd192);
    check("fsCount", 32'(nFs), 32'd2);
    check("fsSpacing", 32'(fsT[1] - fsT[0]), 32'(FRAME));

    // Enable falls exactly on the frame-end tick: one extra full frame, then IDLE.
    Enable = 1'b1;
    @(negedge Clk);
    runPhase("stopAtEnd", 2 * FRAME + 4, 2 * FRAME, FRAME - 1, -1, -1);

    // Asynchronous reset mid-frame at (10,5), then restart from (0,0).
    Enable = 1'b1;
    @(negedge Clk);
    runPhase("preRst", 2 * (HT * 5 + 10), 1 << 30, -1, -1, -1);
    check("preRstH", 32'(HCount), 32'd10);
    check("preRstV", 32'(VCount), 32'd5);
    #2 Reset = 1'b0;
    #1 check("asyncRst", 32'(dutVec()), 32'(IDLE_VEC));
    @(negedge Clk);
    check("rstHeld", 32'(dutVec()), 32'(IDLE_VEC));
    Reset = 1'b1;
    @(negedge Clk);
    runPhase("restart", 64, 1 << 30, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", nChk, nBad);
    $finish;
  end
endmodule
